// File: rtl/rs_bank_param.sv
// rs_bank_param -- parametrised reservation-station bank.
//
// Holds NUM_ENTRIES in-flight ops. Entry i owns tag BASE_TAG+i. Each entry
// snoops the CDB for its pending operands. Ready ops go to a single
// functional-unit port over a valid/ready handshake. An entry is freed when
// its own tag is broadcast on the CDB after dispatch.
//
// Optional feature macro: RS_OLDEST_FIRST_EN
//   defined   : per-entry age counters; dispatch picks the oldest READY entry
//               (ties go to the lowest index)
//   undefined : dispatch picks the lowest-index READY entry
//
// Ports:
//   clk, reset (async, active-high), flush (sync clear of all entries)
//   issue_valid/issue_ready, issue_op, issue_qj/qk, issue_vj/vk -> issue side
//   issue_tag   : tag the current issue receives
//   cdb_valid, cdb_tag, cdb_data : common data bus broadcast
//   disp_valid/disp_ready, disp_op, disp_a/b, disp_tag : FU dispatch port
//   busy_count  : number of occupied entries
module rs_bank_param #(
  parameter int unsigned NUM_ENTRIES = 3,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned OP_W        = 4,
  parameter int unsigned BASE_TAG    = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             issue_valid,
  output logic                             issue_ready,
  input  logic [OP_W-1:0]                  issue_op,
  input  logic [TAG_W-1:0]                 issue_qj,
  input  logic [TAG_W-1:0]                 issue_qk,
  input  logic [XLEN-1:0]                  issue_vj,
  input  logic [XLEN-1:0]                  issue_vk,
  output logic [TAG_W-1:0]                 issue_tag,
  input  logic                             cdb_valid,
  input  logic [TAG_W-1:0]                 cdb_tag,
  input  logic [XLEN-1:0]                  cdb_data,
  output logic                             disp_valid,
  input  logic                             disp_ready,
  output logic [OP_W-1:0]                  disp_op,
  output logic [XLEN-1:0]                  disp_a,
  output logic [XLEN-1:0]                  disp_b,
  output logic [TAG_W-1:0]                 disp_tag,
  output logic [$clog2(NUM_ENTRIES+1)-1:0] busy_count
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_WAIT,
    ST_READY,
    ST_EXEC
  } state_e;

  state_e            state_q [NUM_ENTRIES];
  state_e            state_d [NUM_ENTRIES];
  logic [OP_W-1:0]   op_q    [NUM_ENTRIES];
  logic [OP_W-1:0]   op_d    [NUM_ENTRIES];
  logic [TAG_W-1:0]  qj_q    [NUM_ENTRIES];
  logic [TAG_W-1:0]  qj_d    [NUM_ENTRIES];
  logic [TAG_W-1:0]  qk_q    [NUM_ENTRIES];
  logic [TAG_W-1:0]  qk_d    [NUM_ENTRIES];
  logic [XLEN-1:0]   vj_q    [NUM_ENTRIES];
  logic [XLEN-1:0]   vj_d    [NUM_ENTRIES];
  logic [XLEN-1:0]   vk_q    [NUM_ENTRIES];
  logic [XLEN-1:0]   vk_d    [NUM_ENTRIES];

`ifdef RS_OLDEST_FIRST_EN
  localparam int unsigned AGE_W = IDX_W;
  logic [AGE_W-1:0]  age_q   [NUM_ENTRIES];
  logic [AGE_W-1:0]  age_d   [NUM_ENTRIES];
  logic [AGE_W-1:0]  best_age;
`endif

  // Offer lock: keeps the dispatch selection fixed while it is stalled.
  logic              lock_q, lock_d;
  logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0]  busy_q, busy_d;

  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              rdy_found;
  logic [IDX_W-1:0]  rdy_idx;
  logic              issue_fire;
  logic              disp_fire;
  logic              cdb_hit;

  // Lowest-index free entry.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!free_found && state_q[i] == ST_FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Dispatch selection; a stalled offer overrides any fresh choice.
  always_comb begin
    rdy_found = 1'b0;
    rdy_idx   = '0;
`ifdef RS_OLDEST_FIRST_EN
    best_age  = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (state_q[i] == ST_READY && (!rdy_found || age_q[i] > best_age)) begin
        rdy_found = 1'b1;
        rdy_idx   = IDX_W'(i);
        best_age  = age_q[i];
      end
    end
`else
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!rdy_found && state_q[i] == ST_READY) begin
        rdy_found = 1'b1;
        rdy_idx   = IDX_W'(i);
      end
    end
`endif
    if (lock_q) begin
      rdy_found = 1'b1;
      rdy_idx   = lock_idx_q;
    end
  end

  assign issue_ready = free_found;
  assign issue_tag   = TAG_W'(BASE_TAG) + TAG_W'(free_idx);
  assign issue_fire  = issue_valid & free_found;
  assign cdb_hit     = cdb_valid & (cdb_tag != '0);

  assign disp_valid  = rdy_found;
  assign disp_fire   = rdy_found & disp_ready;
  assign disp_op     = rdy_found ? op_q[rdy_idx] : '0;
  assign disp_a      = rdy_found ? vj_q[rdy_idx] : '0;
  assign disp_b      = rdy_found ? vk_q[rdy_idx] : '0;
  assign disp_tag    = rdy_found ? (TAG_W'(BASE_TAG) + TAG_W'(rdy_idx)) : '0;
  assign busy_count  = busy_q;

  always_comb begin
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      op_d[i]    = op_q[i];
      qj_d[i]    = qj_q[i];
      qk_d[i]    = qk_q[i];
      vj_d[i]    = vj_q[i];
      vk_d[i]    = vk_q[i];
`ifdef RS_OLDEST_FIRST_EN
      age_d[i]   = age_q[i];
`endif
    end
    lock_d     = 1'b0;
    lock_idx_d = rdy_idx;
    busy_d     = '0;

    if (flush) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        state_d[i] = ST_FREE;
        op_d[i]    = '0;
        qj_d[i]    = '0;
        qk_d[i]    = '0;
        vj_d[i]    = '0;
        vk_d[i]    = '0;
`ifdef RS_OLDEST_FIRST_EN
        age_d[i]   = '0;
`endif
      end
    end else begin
      lock_d = rdy_found & ~disp_ready;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        case (state_q[i])
          ST_FREE: begin
            if (issue_fire && free_idx == IDX_W'(i)) begin
              op_d[i] = issue_op;
              // Same-cycle CDB bypass on the issuing operands.
              if (cdb_hit && issue_qj == cdb_tag) begin
                qj_d[i] = '0;
                vj_d[i] = cdb_data;
              end else begin
                qj_d[i] = issue_qj;
                vj_d[i] = issue_vj;
              end
              if (cdb_hit && issue_qk == cdb_tag) begin
                qk_d[i] = '0;
                vk_d[i] = cdb_data;
              end else begin
                qk_d[i] = issue_qk;
                vk_d[i] = issue_vk;
              end
              state_d[i] = (qj_d[i] == '0 && qk_d[i] == '0) ? ST_READY : ST_WAIT;
`ifdef RS_OLDEST_FIRST_EN
              age_d[i] = '0;
`endif
            end
          end
          ST_WAIT: begin
            if (cdb_hit && qj_q[i] == cdb_tag) begin
              qj_d[i] = '0;
              vj_d[i] = cdb_data;
            end
            if (cdb_hit && qk_q[i] == cdb_tag) begin
              qk_d[i] = '0;
              vk_d[i] = cdb_data;
            end
            if (qj_d[i] == '0 && qk_d[i] == '0) state_d[i] = ST_READY;
          end
          ST_READY: begin
            if (disp_fire && rdy_idx == IDX_W'(i)) state_d[i] = ST_EXEC;
          end
          ST_EXEC: begin
            if (cdb_hit && cdb_tag == TAG_W'(BASE_TAG + i)) begin
              state_d[i] = ST_FREE;
              op_d[i]    = '0;
              qj_d[i]    = '0;
              qk_d[i]    = '0;
              vj_d[i]    = '0;
              vk_d[i]    = '0;
            end
          end
          default: state_d[i] = ST_FREE;
        endcase
`ifdef RS_OLDEST_FIRST_EN
        if (issue_fire && state_q[i] != ST_FREE && age_q[i] != '1)
          age_d[i] = age_q[i] + AGE_W'(1);
`endif
      end
    end

    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (state_d[i] != ST_FREE) busy_d = busy_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= ST_FREE;
        op_q[i]    <= '0;
        qj_q[i]    <= '0;
        qk_q[i]    <= '0;
        vj_q[i]    <= '0;
        vk_q[i]    <= '0;
`ifdef RS_OLDEST_FIRST_EN
        age_q[i]   <= '0;
`endif
      end
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      busy_q     <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= state_d[i];
        op_q[i]    <= op_d[i];
        qj_q[i]    <= qj_d[i];
        qk_q[i]    <= qk_d[i];
        vj_q[i]    <= vj_d[i];
        vk_q[i]    <= vk_d[i];
`ifdef RS_OLDEST_FIRST_EN
        age_q[i]   <= age_d[i];
`endif
      end
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      busy_q     <= busy_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && !flush && issue_fire) begin
      assert (issue_qj != issue_tag);
      assert (issue_qk != issue_tag);
    end
    if (!reset && disp_valid) begin
      assert (disp_tag >= TAG_W'(BASE_TAG) &&
              disp_tag <= TAG_W'(BASE_TAG + NUM_ENTRIES - 1));
    end
  end
`endif

endmodule

// File: tb/tb_rs_bank_param.sv
module tb_rs_bank_param;

  localparam int N    = 3;
  localparam int BASE = 1;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        issue_valid, issue_ready;
  logic [3:0]  issue_op, issue_qj, issue_qk, issue_tag;
  logic [31:0] issue_vj, issue_vk;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        disp_valid, disp_ready;
  logic [3:0]  disp_op, disp_tag;
  logic [31:0] disp_a, disp_b;
  logic [1:0]  busy_count;

  int n_tests = 0;
  int n_fail  = 0;

  rs_bank_param #(
    .NUM_ENTRIES(N), .XLEN(32), .TAG_W(4), .OP_W(4), .BASE_TAG(BASE)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_a(disp_a), .disp_b(disp_b), .disp_tag(disp_tag),
    .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  // Reference model: one record per station slot.
  typedef struct {
    bit          occ;   // slot holds an op
    bit          sent;  // op handed to the FU, awaiting its own broadcast
    logic [3:0]  op, qj, qk;
    logic [31:0] vj, vk;
    int          age;
  } ent_t;

  ent_t m [N];
  bit   lock_v;
  int   lock_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int free_idx();
    for (int i = 0; i < N; i++) if (!m[i].occ) return i;
    return -1;
  endfunction

  function automatic bit is_ready(input int i);
    return m[i].occ && !m[i].sent && m[i].qj == 0 && m[i].qk == 0;
  endfunction

  function automatic int pick();
    int best;
    if (lock_v) return lock_i;
    best = -1;
    for (int i = 0; i < N; i++) begin
`ifdef RS_OLDEST_FIRST_EN
      if (is_ready(i) && (best < 0 || m[i].age > m[best].age)) best = i;
`else
      if (is_ready(i) && best < 0) best = i;
`endif
    end
    return best;
  endfunction

  function automatic int occ_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m[i].occ) c++;
    return c;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) m[i] = '{default: 0};
    lock_v = 0;
    lock_i = 0;
  endfunction

  function automatic void model_step(input int f, input int p);
    ent_t o [N];
    bit   ifire, dfire;
    o     = m;
    ifire = issue_valid && f >= 0;
    dfire = p >= 0 && disp_ready;
    if (flush) begin
      model_clear();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (!o[i].occ) continue;
      if (o[i].sent) begin
        if (cdb_valid && int'(cdb_tag) == BASE + i) m[i] = '{default: 0};
      end else if (o[i].qj != 0 || o[i].qk != 0) begin
        if (cdb_valid && o[i].qj == cdb_tag) begin m[i].qj = 0; m[i].vj = cdb_data; end
        if (cdb_valid && o[i].qk == cdb_tag) begin m[i].qk = 0; m[i].vk = cdb_data; end
      end else if (dfire && p == i) begin
        m[i].sent = 1;
      end
      if (ifire && m[i].occ && m[i].age < (1 << $clog2(N)) - 1) m[i].age++;
    end
    if (ifire) begin
      m[f].occ  = 1;
      m[f].sent = 0;
      m[f].op   = issue_op;
      m[f].age  = 0;
      if (cdb_valid && issue_qj != 0 && issue_qj == cdb_tag) begin m[f].qj = 0; m[f].vj = cdb_data; end
      else begin m[f].qj = issue_qj; m[f].vj = issue_vj; end
      if (cdb_valid && issue_qk != 0 && issue_qk == cdb_tag) begin m[f].qk = 0; m[f].vk = cdb_data; end
      else begin m[f].qk = issue_qk; m[f].vk = issue_vk; end
    end
    lock_v = p >= 0 && !disp_ready;
    lock_i = p;
  endfunction

  // Called at a falling edge with inputs applied: checks all outputs against
  // the model, clocks once, advances the model, then idles the inputs.
  task automatic tick();
    int f, p;
    #1;
    f = free_idx();
    p = pick();
    chk("issue_ready", 32'(issue_ready), 32'(f >= 0));
    if (f >= 0) chk("issue_tag", 32'(issue_tag), 32'(BASE + f));
    chk("disp_valid", 32'(disp_valid), 32'(p >= 0));
    chk("disp_tag", 32'(disp_tag), (p >= 0) ? 32'(BASE + p) : 32'd0);
    chk("disp_op", 32'(disp_op), (p >= 0) ? 32'(m[p].op) : 32'd0);
    chk("disp_a", disp_a, (p >= 0) ? m[p].vj : 32'd0);
    chk("disp_b", disp_b, (p >= 0) ? m[p].vk : 32'd0);
    chk("busy_count", 32'(busy_count), 32'(occ_count()));
    @(posedge clk);
    model_step(f, p);
    @(negedge clk);
    issue_valid = 0; cdb_valid = 0; flush = 0; disp_ready = 0;
  endtask

  task automatic set_issue(input logic [3:0] op, input logic [3:0] qj, input logic [31:0] vj,
                           input logic [3:0] qk, input logic [31:0] vk);
    issue_valid = 1; issue_op = op;
    issue_qj = qj; issue_vj = vj; issue_qk = qk; issue_vk = vk;
  endtask

  task automatic set_cdb(input logic [3:0] t, input logic [31:0] d);
    cdb_valid = 1; cdb_tag = t; cdb_data = d;
  endtask

  task automatic chk_idle(input string pfx);
    chk({pfx, "_issue_ready"}, 32'(issue_ready), 32'd1);
    chk({pfx, "_issue_tag"},   32'(issue_tag),   32'(BASE));
    chk({pfx, "_disp_valid"},  32'(disp_valid),  32'd0);
    chk({pfx, "_disp_op"},     32'(disp_op),     32'd0);
    chk({pfx, "_disp_a"},      disp_a,           32'd0);
    chk({pfx, "_disp_b"},      disp_b,           32'd0);
    chk({pfx, "_disp_tag"},    32'(disp_tag),    32'd0);
    chk({pfx, "_busy"},        32'(busy_count),  32'd0);
  endtask

  initial begin
    reset = 1; flush = 0; issue_valid = 0; issue_op = 0; issue_qj = 0; issue_qk = 0;
    issue_vj = 0; issue_vk = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0; disp_ready = 0;
    model_clear();
    #1 chk_idle("reset");
    @(negedge clk);
    reset = 0;

    // Ready-at-issue op dispatches the next cycle, then frees on its own tag.
    set_issue(4'd2, 4'd0, 32'd5, 4'd0, 32'd7);
    #1 chk("t1_issue_tag", 32'(issue_tag), 32'd1);
    tick();
    #1 chk("t1_disp_valid", 32'(disp_valid), 32'd1);
    chk("t1_disp_a", disp_a, 32'd5);
    chk("t1_disp_b", disp_b, 32'd7);
    chk("t1_disp_tag", 32'(disp_tag), 32'd1);
    disp_ready = 1; tick();
    set_cdb(4'd1, 32'd0); tick();
    #1 chk("t1_busy_free", 32'(busy_count), 32'd0);

    // Operand arrives through CDB snoop; zero-latency offer.
    set_issue(4'd1, 4'd4, 32'hAA, 4'd0, 32'd3); tick();
    tick();
    set_cdb(4'd4, 32'h10); tick();
    #1 chk("t2_disp_a", disp_a, 32'h10);
    chk("t2_disp_b", disp_b, 32'd3);
    disp_ready = 1; tick();
    set_cdb(4'd1, 32'd0); tick();

    // Issue-cycle bypass.
    set_issue(4'd3, 4'd6, 32'd0, 4'd0, 32'd1);
    set_cdb(4'd6, 32'd9); tick();
    #1 chk("t3_disp_valid", 32'(disp_valid), 32'd1);
    chk("t3_disp_a", disp_a, 32'd9);
    disp_ready = 1; tick();
    set_cdb(4'd1, 32'd0); tick();

    // Fill, drop, stalled offer stays put, then free tag 2.
    set_issue(4'd4, 4'd0, 32'd11, 4'd0, 32'd12); tick();
    set_issue(4'd5, 4'd0, 32'd21, 4'd0, 32'd22); tick();
    set_issue(4'd6, 4'd7, 32'd31, 4'd0, 32'd32); tick();
    #1 chk("t4_full_ready", 32'(issue_ready), 32'd0);
    chk("t4_full_busy", 32'(busy_count), 32'd3);
    set_issue(4'd9, 4'd0, 32'd99, 4'd0, 32'd99); tick();
    #1 chk("t4_drop_busy", 32'(busy_count), 32'd3);
    for (int c = 0; c < 5; c++) begin
      #1 chk("t5_hold_tag", 32'(disp_tag), 32'd1);
      tick();
    end
    disp_ready = 1; tick();
    #1 chk("t5_next_tag", 32'(disp_tag), 32'd2);
    disp_ready = 1; tick();
    set_cdb(4'd2, 32'd0);
    #1 chk("t4_same_cycle_ready", 32'(issue_ready), 32'd0);
    tick();
    #1 chk("t4_freed_ready", 32'(issue_ready), 32'd1);
    chk("t4_freed_tag", 32'(issue_tag), 32'd2);

    // Flush with all three busy.
    set_issue(4'd1, 4'd0, 32'd1, 4'd0, 32'd2); tick();
    #1 chk("t6_busy", 32'(busy_count), 32'd3);
    flush = 1; tick();
    #1 chk_idle("flush");

    // Asynchronous reset mid-operation.
    for (int c = 0; c < 3; c++) begin
      set_issue(4'(c), 4'd0, 32'(c), 4'd0, 32'(c + 1)); tick();
    end
    reset = 1;
    #1 chk_idle("midreset");
    model_clear();
    @(negedge clk);
    reset = 0;

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int f;
      f = free_idx();
      issue_valid = 1'($urandom_range(0, 1));
      issue_op    = 4'($urandom);
      issue_qj    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0;
      issue_qk    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0;
      if (f >= 0 && int'(issue_qj) == BASE + f) issue_qj = 4'd0;
      if (f >= 0 && int'(issue_qk) == BASE + f) issue_qk = 4'd0;
      issue_vj    = $urandom;
      issue_vk    = $urandom;
      cdb_valid   = 1'($urandom_range(0, 1));
      cdb_tag     = 4'($urandom_range(1, 7));
      cdb_data    = $urandom;
      disp_ready  = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
